flexcounter_multi: RTL and testbench

Parametrised multi-channel successor to the single flex counter: CHANNELS independent terminal-count counters sharing one clock, each with a per-channel terminal value, a synchronous clear and a periodic or one-shot mode. Used by timing controllers that need several concurrent intervals (debounce, blink, timeout) without instantiating one counter per interval. All outputs are registered. An optional shared prescaler slows every channel by a common divide ratio.

---
 rtl/flexcounter_multi_if.sv | 47 ++++
 rtl/flexcounter_multi.sv | 96 +++++++++
 tb/tb_flexcounter_multi.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/flexcounter_multi_if.sv
//==============================================================================
// Module : flexcounter_multi_if
// Brief  : Control/status bundle for flexcounter_multi; the prescale field
//          exists only when FLEXCOUNTER_PRESCALE_EN is defined.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface flexcounter_multi_if #(
  parameter int CHANNELS       = 4,
  parameter int COUNTWIDTH     = 10,
  parameter int PRESCALE_WIDTH = 8
);
  logic [CHANNELS-1:0]                 enableCounter;
  logic [CHANNELS-1:0]                 clear;
  logic [CHANNELS-1:0]                 oneShot;
  logic [CHANNELS-1:0][COUNTWIDTH-1:0] maxCount;
`ifdef FLEXCOUNTER_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0]           prescale;
`endif
  logic [CHANNELS-1:0]                 strobe;
  logic [CHANNELS-1:0][COUNTWIDTH-1:0] count;
  logic [CHANNELS-1:0]                 done;
  logic                                anyStrobe;

`ifdef FLEXCOUNTER_PRESCALE_EN
  modport master (
    output enableCounter, clear, oneShot, maxCount, prescale,
    input  strobe, count, done, anyStrobe
  );
  modport slave (
    input  enableCounter, clear, oneShot, maxCount, prescale,
    output strobe, count, done, anyStrobe
  );
`else
  modport master (
    output enableCounter, clear, oneShot, maxCount,
    input  strobe, count, done, anyStrobe
  );
  modport slave (
    input  enableCounter, clear, oneShot, maxCount,
    output strobe, count, done, anyStrobe
  );
`endif
endinterface

`default_nettype wire

// File: rtl/flexcounter_multi.sv
//==============================================================================
// Module : flexcounter_multi
// Brief  : CHANNELS independent terminal-count counters with periodic/one-shot
//          modes; optional shared prescaler via FLEXCOUNTER_PRESCALE_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module flexcounter_multi #(
  parameter int CHANNELS       = 4,
  parameter int COUNTSIZE      = 1024,
  parameter int PRESCALE_WIDTH = 8
) (
  input  wire logic            clk,
  input  wire logic            nRST,
  flexcounter_multi_if.slave   bus
);

  localparam int COUNTWIDTH = $clog2(COUNTSIZE);

  logic                                w_tick;
  logic [CHANNELS-1:0][COUNTWIDTH-1:0] r_count;
  logic [CHANNELS-1:0]                 r_strobe;
  logic [CHANNELS-1:0]                 r_done;
  logic                                r_any_strobe;
  logic [CHANNELS-1:0][COUNTWIDTH-1:0] w_cnt_nxt;
  logic [CHANNELS-1:0]                 w_stb_nxt;
  logic [CHANNELS-1:0]                 w_done_nxt;

`ifdef FLEXCOUNTER_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] r_prescaler;
  logic                      w_any_en;

  assign w_any_en = |bus.enableCounter;
  // >= so a prescale lowered beneath the running value ticks immediately
  assign w_tick   = w_any_en && (r_prescaler >= bus.prescale);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_prescaler <= '0;
    end else if (!w_any_en || w_tick) begin
      r_prescaler <= '0;
    end else begin
      r_prescaler <= r_prescaler + PRESCALE_WIDTH'(1);
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  always_comb begin
    w_cnt_nxt  = r_count;
    w_done_nxt = r_done;
    w_stb_nxt  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.clear[i]) begin
        w_cnt_nxt[i]  = '0;
        w_done_nxt[i] = 1'b0;
      end else if (bus.enableCounter[i] && w_tick && !r_done[i]) begin
        // Terminal checked before increment, so the count can never wrap
        if (r_count[i] >= bus.maxCount[i]) begin
          w_stb_nxt[i] = 1'b1;
          if (bus.oneShot[i]) begin
            w_done_nxt[i] = 1'b1;
          end else begin
            w_cnt_nxt[i] = '0;
          end
        end else begin
          w_cnt_nxt[i] = r_count[i] + COUNTWIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_count      <= '0;
      r_strobe     <= '0;
      r_done       <= '0;
      r_any_strobe <= 1'b0;
    end else begin
      r_count      <= w_cnt_nxt;
      r_strobe     <= w_stb_nxt;
      r_done       <= w_done_nxt;
      r_any_strobe <= |w_stb_nxt;
    end
  end

  assign bus.count     = r_count;
  assign bus.strobe    = r_strobe;
  assign bus.done      = r_done;
  assign bus.anyStrobe = r_any_strobe;

endmodule

`default_nettype wire

// File: tb/tb_flexcounter_multi.sv
//==============================================================================
// Module : tb_flexcounter_multi
// Brief  : Directed scoreboard bench for flexcounter_multi (4 ch, 10-bit).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_flexcounter_multi;

  localparam int CH = 4;
  localparam int CW = 10;

  typedef logic [CH-1:0][CW-1:0] cvec_t;
  typedef struct {
    cvec_t          cnt;
    logic [CH-1:0]  stb;
    logic [CH-1:0]  dn;
    logic           any;
    int             id;
  } exp_t;

  logic  clk = 1'b0;
  logic  nRST = 1'b0;
  cvec_t mx;
  exp_t  q[$];
  int    nvec = 0;
  int    nmis = 0;
  int    vid  = 0;

  flexcounter_multi_if #(.CHANNELS(CH), .COUNTWIDTH(CW), .PRESCALE_WIDTH(8)) bus ();

  flexcounter_multi #(.CHANNELS(CH), .COUNTSIZE(1024), .PRESCALE_WIDTH(8)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic cvec_t c4(input int a, input int b, input int c, input int d);
    cvec_t r;
    r[0] = CW'(a);
    r[1] = CW'(b);
    r[2] = CW'(c);
    r[3] = CW'(d);
    return r;
  endfunction

  // Drive one vector at the falling edge; expectation is for the next rising edge
  task automatic step(input logic rn, input logic [CH-1:0] en, input logic [CH-1:0] clr,
                      input logic [CH-1:0] os, input cvec_t ec, input logic [CH-1:0] es,
                      input logic [CH-1:0] ed);
    exp_t e;
    @(negedge clk);
    nRST              = rn;
    bus.enableCounter = en;
    bus.clear         = clr;
    bus.oneShot       = os;
    bus.maxCount      = mx;
    e.cnt = ec;
    e.stb = es;
    e.dn  = ed;
    e.any = |es;
    e.id  = vid;
    vid++;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        nvec++;
        if (bus.count !== e.cnt || bus.strobe !== e.stb || bus.done !== e.dn ||
            bus.anyStrobe !== e.any) begin
          nmis++;
          $display("FAIL vec%0d: got cnt=%h stb=%b done=%b any=%b, want cnt=%h stb=%b done=%b any=%b",
                   e.id, bus.count, bus.strobe, bus.done, bus.anyStrobe,
                   e.cnt, e.stb, e.dn, e.any);
        end
      end
    end
  end

  initial begin : stim
    bus.enableCounter = '0;
    bus.clear         = '0;
    bus.oneShot       = '0;
    mx                = c4(5, 5, 5, 5);
    bus.maxCount      = mx;
`ifdef FLEXCOUNTER_PRESCALE_EN
    bus.prescale      = 8'd0;
`endif

    // Reset held with all channels enabled
    step(1'b0, 4'hF, 4'h0, 4'h0, c4(0, 0, 0, 0), 4'h0, 4'h0);
    step(1'b0, 4'hF, 4'h0, 4'h0, c4(0, 0, 0, 0), 4'h0, 4'h0);
    step(1'b1, 4'hF, 4'h0, 4'h0, c4(1, 1, 1, 1), 4'h0, 4'h0);
    step(1'b1, 4'hF, 4'h0, 4'h0, c4(2, 2, 2, 2), 4'h0, 4'h0);
    step(1'b1, 4'hF, 4'h0, 4'h0, c4(3, 3, 3, 3), 4'h0, 4'h0);
    step(1'b1, 4'hF, 4'hF, 4'h0, c4(0, 0, 0, 0), 4'h0, 4'h0);

    // Periodic ch0, maxCount=3
    mx = c4(3, 5, 5, 5);
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 4'b0001, 4'h0, 4'h0, c4(k % 4, 0, 0, 0),
           (k % 4 == 0) ? 4'b0001 : 4'b0000, 4'h0);
    end

    // One-shot ch1, maxCount=2
    mx = c4(3, 2, 5, 5);
    step(1'b1, 4'b0010, 4'h0, 4'b0010, c4(0, 1, 0, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0010, 4'h0, 4'b0010, c4(0, 2, 0, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0010, 4'h0, 4'b0010, c4(0, 2, 0, 0), 4'b0010, 4'b0010);
    step(1'b1, 4'b0010, 4'h0, 4'b0010, c4(0, 2, 0, 0), 4'b0000, 4'b0010);
    step(1'b1, 4'b0010, 4'h0, 4'b0000, c4(0, 2, 0, 0), 4'b0000, 4'b0010);
    step(1'b1, 4'b0010, 4'b0010, 4'b0000, c4(0, 0, 0, 0), 4'b0000, 4'b0000);
    mx = c4(3, 0, 5, 5);
    step(1'b1, 4'b0010, 4'h0, 4'b0010, c4(0, 0, 0, 0), 4'b0010, 4'b0010);
    step(1'b1, 4'b0010, 4'b0010, 4'b0010, c4(0, 0, 0, 0), 4'b0000, 4'b0000);

    // Clear beats terminal on ch2; ch0/ch3 terminate together
    mx = c4(4, 0, 1, 4);
    step(1'b1, 4'b0100, 4'h0, 4'h0, c4(0, 0, 1, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0100, 4'b0100, 4'h0, c4(0, 0, 0, 0), 4'b0000, 4'b0000);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 4'b1001, 4'h0, 4'h0, c4(k, 0, 0, k), 4'b0000, 4'b0000);
    end
    step(1'b1, 4'b1001, 4'h0, 4'h0, c4(0, 0, 0, 0), 4'b1001, 4'b0000);

    // maxCount lowered under the running count, then zero
    mx = c4(10, 0, 1, 4);
    for (int k = 1; k <= 7; k++) begin
      step(1'b1, 4'b0001, 4'h0, 4'h0, c4(k, 0, 0, 0), 4'b0000, 4'b0000);
    end
    mx = c4(2, 0, 1, 4);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(0, 0, 0, 0), 4'b0001, 4'b0000);
    mx = c4(0, 0, 1, 4);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'b0001, 4'h0, 4'h0, c4(0, 0, 0, 0), 4'b0001, 4'b0000);
    end

    // Asynchronous reset mid-count
    mx = c4(10, 0, 1, 4);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(1, 0, 0, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(2, 0, 0, 0), 4'b0000, 4'b0000);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    nRST = 1'b0;
    #1;
    nvec++;
    if (bus.count !== c4(0, 0, 0, 0) || bus.strobe !== 4'h0 || bus.done !== 4'h0) begin
      nmis++;
      $display("FAIL async_rst: got cnt=%h stb=%b done=%b, want all zero",
               bus.count, bus.strobe, bus.done);
    end
    step(1'b0, 4'b0001, 4'h0, 4'h0, c4(0, 0, 0, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(1, 0, 0, 0), 4'b0000, 4'b0000);

`ifdef FLEXCOUNTER_PRESCALE_EN
    // prescale=2, maxCount=1: one tick every 3 cycles
    mx = c4(1, 0, 1, 4);
    bus.prescale = 8'd2;
    step(1'b1, 4'b0000, 4'b0001, 4'h0, c4(0, 0, 0, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(0, 0, 0, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(0, 0, 0, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(1, 0, 0, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(1, 0, 0, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(1, 0, 0, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(0, 0, 0, 0), 4'b0001, 4'b0000);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(0, 0, 0, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(0, 0, 0, 0), 4'b0000, 4'b0000);
    // All enables low returns the prescaler to 0
    step(1'b1, 4'b0000, 4'h0, 4'h0, c4(0, 0, 0, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(0, 0, 0, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(0, 0, 0, 0), 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, 4'h0, 4'h0, c4(1, 0, 0, 0), 4'b0000, 4'b0000);
`endif

    for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
